// File: rtl/inv_sub_bytes_iter.sv
// inv_sub_bytes_iter: iterative AES InvSubBytes over a 128-bit state.
// BYTES_PER_CYCLE bytes are substituted per clock, so a state takes
// 16/BYTES_PER_CYCLE cycles in RUN. Byte positions are never permuted.
// Optional feature macro SBOX_FWD_MODE_EN adds a mode_fwd input that,
// sampled on the accepting edge, switches that transaction to the
// forward S-box.
module inv_sub_bytes_iter #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef SBOX_FWD_MODE_EN
  input  logic         mode_fwd,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int N     = 16 / BYTES_PER_CYCLE;
  localparam int GW    = 8 * BYTES_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
      BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
    $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Table entry i lives at bits [8*(255-i) +: 8], i.e. entry 0 is leftmost.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad5_3036a538_bf40a39e_81f3d7fb, 128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
    128'h547b9432_a6c2233d_ee4c950b_42fac34e, 128'h082ea166_28d924b2_765ba249_6d8bd125,
    128'h72f8f664_86689816_d4a45ccc_5d65b692, 128'h6c704850_fdedb9da_5e154657_a78d9d84,
    128'h90d8ab00_8cbcd30a_f7e45805_b8b34506, 128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
    128'h3a911141_4f67dcea_97f2cfce_f0b4e673, 128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
    128'h47f11a71_1d29c589_6fb7620e_aa18be1b, 128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
    128'h1fdda833_8807c731_b1121059_2780ec5f, 128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
    128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961, 128'h172b047e_ba77d626_e1691463_55210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b000} +: 8];
  endfunction

`ifdef SBOX_FWD_MODE_EN
  localparam logic [2047:0] FWD_SBOX = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76, 128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115, 128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84, 128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8, 128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973, 128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479, 128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a, 128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df, 128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
    return FWD_SBOX[{~b, 3'b000} +: 8];
  endfunction

  logic fwd_q;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [127:0]     work_q;
  logic [127:0]     work_d;
  logic [GW-1:0]    grp_in;
  logic [GW-1:0]    grp_out;

  // Select the byte group addressed by the group counter.
  always_comb begin
    grp_in = '0;
    for (int g = 0; g < N; g++) begin
      if (cnt_q == CNT_W'(g)) grp_in = work_q[g*GW +: GW];
    end
  end

  // One S-box lookup per byte lane of the group.
  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
`ifdef SBOX_FWD_MODE_EN
    assign grp_out[8*j +: 8] = fwd_q ? fwd_sbox(grp_in[8*j +: 8])
                                     : inv_sbox(grp_in[8*j +: 8]);
`else
    assign grp_out[8*j +: 8] = inv_sbox(grp_in[8*j +: 8]);
`endif
  end

  // Merge the substituted group back into its original byte positions.
  always_comb begin
    work_d = work_q;
    for (int g = 0; g < N; g++) begin
      if (cnt_q == CNT_W'(g)) work_d[g*GW +: GW] = grp_out;
    end
  end

  // Control FSM: accept in IDLE, walk the groups in RUN, hold result in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
`ifdef SBOX_FWD_MODE_EN
      fwd_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q  <= in_data;
            cnt_q   <= '0;
            state_q <= RUN;
`ifdef SBOX_FWD_MODE_EN
            fwd_q   <= mode_fwd;
`endif
          end
        end
        RUN: begin
          work_q <= work_d;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Testbench for inv_sub_bytes_iter: S-boxes are derived from GF(2^8)
// arithmetic, a transaction-level timing model predicts every cycle of
// the BYTES_PER_CYCLE=4 instance, and two extra instances cover the
// BYTES_PER_CYCLE=1 and 16 latencies.
`timescale 1ns/1ps
module tb_inv_sub_bytes_iter;

  localparam int N_MAIN = 4;
`ifdef SBOX_FWD_MODE_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_ready, out_valid, out_ready, mode_fwd;
  logic [127:0] in_data, out_data;

  logic         alt_in_valid, alt_out_ready, alt_mode;
  logic [127:0] alt_in_data;
  logic         a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [127:0] a_out_data, b_out_data;

  inv_sub_bytes_iter #(.BYTES_PER_CYCLE(4)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SBOX_FWD_MODE_EN
    .mode_fwd(mode_fwd),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n),
`ifdef SBOX_FWD_MODE_EN
    .mode_fwd(alt_mode),
`endif
    .in_valid(alt_in_valid), .in_ready(a_in_ready), .in_data(alt_in_data),
    .out_valid(a_out_valid), .out_ready(alt_out_ready), .out_data(a_out_data)
  );

  inv_sub_bytes_iter #(.BYTES_PER_CYCLE(16)) dut_b16 (
    .clk(clk), .rst_n(rst_n),
`ifdef SBOX_FWD_MODE_EN
    .mode_fwd(alt_mode),
`endif
    .in_valid(alt_in_valid), .in_ready(b_in_ready), .in_data(alt_in_data),
    .out_valid(b_out_valid), .out_ready(alt_out_ready), .out_data(b_out_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %0s: got %h expected %h (t=%0t)", name, got, exp, $time);
    else n_pass++;
  endtask

  // Reference S-boxes built from field arithmetic.
  logic [7:0] m_fwd [256];
  logic [7:0] m_inv [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] v, s;
    for (int a = 0; a < 256; a++) begin
      v = 8'h00;
      for (int b = 1; b < 256; b++) if (gf_mul(8'(a), 8'(b)) == 8'h01) v = 8'(b);
      s = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
      m_fwd[a] = s;
      m_inv[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] sub128(input logic [127:0] d, input logic fwd);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = fwd ? m_fwd[d[8*k +: 8]] : m_inv[d[8*k +: 8]];
    return r;
  endfunction

  // Transaction-level model of the main instance.
  bit           m_init = 0, m_busy = 0, m_valid = 0, m_known = 0;
  int           m_wait = 0;
  logic [127:0] m_out = '0, m_res = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init = 1; m_busy = 0; m_valid = 0; m_wait = 0; m_known = 1; m_out = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1; m_wait = N_MAIN; m_known = 0;
        m_res = sub128(in_data, FWD_EN && mode_fwd);
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin m_valid = 1; m_out = m_res; m_known = 1; end
    end else if (out_ready) begin
      m_busy = 0; m_valid = 0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk("cyc_in_ready", 128'(in_ready), 128'(!m_busy && rst_n));
      chk("cyc_out_valid", 128'(out_valid), 128'(m_valid));
      if (m_known) chk("cyc_out_data", out_data, m_out);
    end
  end

  task automatic send(input logic [127:0] d, input logic fwd);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin @(posedge clk); #2; guard++; end
    chk("accept_wait", 128'(guard < 50), 128'd1);
    in_valid = 1'b1; in_data = d; mode_fwd = fwd;
    @(posedge clk); #2;
    in_valid = 1'b0; in_data = {$urandom, $urandom, $urandom, $urandom};
    mode_fwd = FWD_EN ? 1'($urandom) : 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin @(posedge clk); #2; lat++; end
    chk("valid_wait", 128'(lat < 64), 128'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, n_pass %0d n_checks %0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int lat, seen, lat_a, lat_b;
    logic [127:0] d, hold, cap_a, cap_b;
    logic [127:0] all52, all63;
    all52 = {16{8'h52}};
    all63 = {16{8'h63}};
    build_tables();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; mode_fwd = 1'b0;
    alt_in_valid = 1'b0; alt_in_data = '0; alt_out_ready = 1'b0; alt_mode = 1'b0;

    chk("model_inv_00", 128'(m_inv[8'h00]), 128'h52);
    chk("model_inv_ed", 128'(m_inv[8'hed]), 128'h53);
    chk("model_fwd_00", 128'(m_fwd[8'h00]), 128'h63);

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #2;

    // All 0x63 -> all 0x00, latency 4
    out_ready = 1'b1;
    send(all63, 1'b0);
    wait_valid(lat);
    chk("lat_63", 128'(lat), 128'd4);
    chk("out_63", out_data, 128'd0);
    @(posedge clk); #2;

    // Known byte pattern, positions preserved
    send(128'hED7C1600_ED7C1600_ED7C1600_ED7C1600, 1'b0);
    wait_valid(lat);
    chk("out_pattern", out_data, 128'h5301FF52_5301FF52_5301FF52_5301FF52);
    @(posedge clk); #2;

    // Back-pressure hold in DONE
    out_ready = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 1'b0);
    wait_valid(lat);
    hold = out_data;
    chk("hold_result", hold, sub128(d, 1'b0));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom); in_data = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #2;
      chk("hold_valid", 128'(out_valid), 128'd1);
      chk("hold_data", out_data, hold);
      chk("hold_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #2;
    chk("release_valid", 128'(out_valid), 128'd0);
    chk("release_in_ready", 128'(in_ready), 128'd1);

    // Reset during RUN at cnt=2
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 1'b0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #2;
    end
    chk("abandoned_no_valid", 128'(seen), 128'd0);
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d, 1'b0);
    wait_valid(lat);
    chk("after_rst_lat", 128'(lat), 128'd4);
    chk("after_rst_data", out_data, sub128(d, 1'b0));
    @(posedge clk); #2;

    // BYTES_PER_CYCLE = 1 and 16 latencies
    chk("alt_ready_b1", 128'(a_in_ready), 128'd1);
    chk("alt_ready_b16", 128'(b_in_ready), 128'd1);
    alt_out_ready = 1'b1; alt_in_data = '0; alt_in_valid = 1'b1;
    @(posedge clk); #2;
    alt_in_valid = 1'b0; alt_in_data = {$urandom, $urandom, $urandom, $urandom};
    lat_a = -1; lat_b = -1; cap_a = '0; cap_b = '0;
    for (int i = 0; i < 24; i++) begin
      if (a_out_valid && lat_a < 0) begin lat_a = i; cap_a = a_out_data; end
      if (b_out_valid && lat_b < 0) begin lat_b = i; cap_b = b_out_data; end
      @(posedge clk); #2;
    end
    chk("lat_b1", 128'(lat_a), 128'd16);
    chk("lat_b16", 128'(lat_b), 128'd1);
    chk("out_b1", cap_a, all52);
    chk("out_b16", cap_b, all52);

`ifdef SBOX_FWD_MODE_EN
    send('0, 1'b1);
    wait_valid(lat);
    chk("fwd_zero", out_data, all63);
    @(posedge clk); #2;
`endif
    send('0, 1'b0);
    wait_valid(lat);
    chk("inv_zero", out_data, all52);
    @(posedge clk); #2;

    // Randomized traffic checked by the per-cycle model
    for (int i = 0; i < 1500; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      in_valid  = 1'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      mode_fwd  = FWD_EN ? 1'($urandom) : 1'b0;
      @(posedge clk); #2;
    end
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #2;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
